// File: rtl/voice_allocator_if.sv
// Request/commit bundle between a note source and the voice allocator.
// The allocator side uses the slave modport; the note source uses master.
interface voice_allocator_if #(
    parameter int VOICES  = 32,
    parameter int V_WIDTH = $clog2(VOICES)
);
    logic               note_on_req;
    logic               note_off_req;
    logic [6:0]         req_key;
    logic [6:0]         req_vel;
    logic [VOICES-1:0]  voice_free;
    logic               busy;
    logic               note_on;
    logic               note_off;
    logic [V_WIDTH-1:0] cur_key_adr;
    logic [7:0]         cur_key_val;
    logic [7:0]         cur_vel_on;
    logic [7:0]         cur_vel_off;
    logic [VOICES-1:0]  keys_on;
    logic [V_WIDTH:0]   active_keys;
    logic               steal;
    logic               drop;
    logic               off_note_error;

    modport master (
        output note_on_req, note_off_req, req_key, req_vel, voice_free,
        input  busy, note_on, note_off, cur_key_adr, cur_key_val, cur_vel_on,
               cur_vel_off, keys_on, active_keys, steal, drop, off_note_error
    );

    modport slave (
        input  note_on_req, note_off_req, req_key, req_vel, voice_free,
        output busy, note_on, note_off, cur_key_adr, cur_key_val, cur_vel_on,
               cur_vel_off, keys_on, active_keys, steal, drop, off_note_error
    );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: scans one voice per cycle, then commits a
// key-on (retrigger / free / releasing / steal) or key-off in a single cycle.
module voice_allocator #(
    parameter int VOICES     = 32,
    parameter int V_WIDTH    = $clog2(VOICES),
    parameter int STEAL_MODE = 1
) (
    input  logic             CLOCK_25,
    input  logic             reset_reg,
    voice_allocator_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t             r_state;
    logic               r_isOff;
    logic [6:0]         r_key;
    logic [6:0]         r_vel;
    logic [V_WIDTH-1:0] r_scanIdx;

    // Best candidate found so far for each selection class.
    logic               r_matchFound, r_freeFound, r_relFound, r_heldFound;
    logic [V_WIDTH-1:0] r_matchIdx, r_freeIdx, r_relIdx, r_heldIdx;
    logic [V_WIDTH-1:0] r_relRank, r_heldRank;

    logic [V_WIDTH-1:0] r_rank   [VOICES];
    logic [6:0]         r_keyMap [VOICES];
    logic [VOICES-1:0]  r_keysOn;
    logic [V_WIDTH:0]   r_activeKeys;

    logic               r_busy, r_noteOn, r_noteOff, r_steal, r_drop, r_offErr;
    logic [V_WIDTH-1:0] r_curAdr;
    logic [7:0]         r_curKey, r_curVelOn, r_curVelOff;

    logic [V_WIDTH-1:0] w_onIdx;
    logic               w_onValid, w_steal, w_newSlot;
    logic [V_WIDTH-1:0] w_scanRank;
    logic               w_scanHeld, w_scanFree, w_scanMatch;

    assign w_scanRank  = r_rank[r_scanIdx];
    assign w_scanHeld  = r_keysOn[r_scanIdx];
    assign w_scanFree  = bus.voice_free[r_scanIdx];
    assign w_scanMatch = w_scanHeld && (r_keyMap[r_scanIdx] == r_key);

    always_comb begin
        w_onIdx   = r_matchIdx;
        w_onValid = 1'b1;
        w_steal   = 1'b0;
        w_newSlot = 1'b0;
        if (r_matchFound) begin
            w_onIdx = r_matchIdx;
        end else if (r_freeFound) begin
            w_onIdx   = r_freeIdx;
            w_newSlot = 1'b1;
        end else if (r_relFound) begin
            w_onIdx   = r_relIdx;
            w_newSlot = 1'b1;
        end else if (STEAL_MODE != 0 && r_heldFound) begin
            w_onIdx = r_heldIdx;
            w_steal = 1'b1;
        end else begin
            w_onValid = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_25 or posedge reset_reg) begin
        if (reset_reg) begin
            r_state      <= IDLE;
            r_isOff      <= 1'b0;
            r_key        <= '0;
            r_vel        <= '0;
            r_scanIdx    <= '0;
            r_matchFound <= 1'b0;
            r_freeFound  <= 1'b0;
            r_relFound   <= 1'b0;
            r_heldFound  <= 1'b0;
            r_matchIdx   <= '0;
            r_freeIdx    <= '0;
            r_relIdx     <= '0;
            r_heldIdx    <= '0;
            r_relRank    <= '0;
            r_heldRank   <= '0;
            for (int i = 0; i < VOICES; i++) begin
                r_rank[i]   <= V_WIDTH'(i);
                r_keyMap[i] <= '0;
            end
            r_keysOn     <= '0;
            r_activeKeys <= '0;
            r_busy       <= 1'b0;
            r_noteOn     <= 1'b0;
            r_noteOff    <= 1'b0;
            r_steal      <= 1'b0;
            r_drop       <= 1'b0;
            r_offErr     <= 1'b0;
            r_curAdr     <= '0;
            r_curKey     <= '0;
            r_curVelOn   <= '0;
            r_curVelOff  <= '0;
        end else begin
            r_noteOn  <= 1'b0;
            r_noteOff <= 1'b0;
            r_steal   <= 1'b0;
            r_drop    <= 1'b0;
            r_offErr  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.note_off_req || bus.note_on_req) begin
                        r_isOff      <= bus.note_off_req;
                        r_key        <= bus.req_key;
                        r_vel        <= bus.req_vel;
                        r_scanIdx    <= '0;
                        r_matchFound <= 1'b0;
                        r_freeFound  <= 1'b0;
                        r_relFound   <= 1'b0;
                        r_heldFound  <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_scanMatch && !r_matchFound) begin
                        r_matchFound <= 1'b1;
                        r_matchIdx   <= r_scanIdx;
                    end
                    if (!w_scanHeld && w_scanFree && !r_freeFound) begin
                        r_freeFound <= 1'b1;
                        r_freeIdx   <= r_scanIdx;
                    end
                    if (!w_scanHeld && !w_scanFree && (!r_relFound || w_scanRank > r_relRank)) begin
                        r_relFound <= 1'b1;
                        r_relIdx   <= r_scanIdx;
                        r_relRank  <= w_scanRank;
                    end
                    if (w_scanHeld && (!r_heldFound || w_scanRank > r_heldRank)) begin
                        r_heldFound <= 1'b1;
                        r_heldIdx   <= r_scanIdx;
                        r_heldRank  <= w_scanRank;
                    end
                    if (r_scanIdx == V_WIDTH'(VOICES - 1)) begin
                        r_state <= COMMIT;
                    end else begin
                        r_scanIdx <= r_scanIdx + V_WIDTH'(1);
                    end
                end
                COMMIT: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    if (r_isOff) begin
                        if (r_matchFound) begin
                            r_keysOn[r_matchIdx] <= 1'b0;
                            r_activeKeys         <= r_activeKeys - (V_WIDTH + 1)'(1);
                            r_curAdr             <= r_matchIdx;
                            r_curKey             <= {1'b0, r_key};
                            r_curVelOff          <= {1'b0, r_vel};
                            r_noteOff            <= 1'b1;
                        end else begin
                            r_offErr <= 1'b1;
                        end
                    end else if (w_onValid) begin
                        // Age the voices younger than the chosen one; it becomes newest.
                        for (int i = 0; i < VOICES; i++) begin
                            if (r_rank[i] < r_rank[w_onIdx]) begin
                                r_rank[i] <= r_rank[i] + V_WIDTH'(1);
                            end
                        end
                        r_rank[w_onIdx]   <= '0;
                        r_keyMap[w_onIdx] <= r_key;
                        r_keysOn[w_onIdx] <= 1'b1;
                        if (w_newSlot) begin
                            r_activeKeys <= r_activeKeys + (V_WIDTH + 1)'(1);
                        end
                        r_curAdr   <= w_onIdx;
                        r_curKey   <= {1'b0, r_key};
                        r_curVelOn <= {1'b0, r_vel};
                        r_noteOn   <= 1'b1;
                        r_steal    <= w_steal;
                    end else begin
                        r_drop <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy           = r_busy;
    assign bus.note_on        = r_noteOn;
    assign bus.note_off       = r_noteOff;
    assign bus.steal          = r_steal;
    assign bus.drop           = r_drop;
    assign bus.off_note_error = r_offErr;
    assign bus.cur_key_adr    = r_curAdr;
    assign bus.cur_key_val    = r_curKey;
    assign bus.cur_vel_on     = r_curVelOn;
    assign bus.cur_vel_off    = r_curVelOff;
    assign bus.keys_on        = r_keysOn;
    assign bus.active_keys    = r_activeKeys;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with four voices; two instances run in
// lockstep, one stealing and one dropping when every voice is held.
module tb_voice_allocator;

    localparam int VOICES = 4;
    localparam logic [4:0] P_NONE  = 5'b00000;
    localparam logic [4:0] P_ON    = 5'b10000;
    localparam logic [4:0] P_OFF   = 5'b01000;
    localparam logic [4:0] P_STEAL = 5'b00100;
    localparam logic [4:0] P_DROP  = 5'b00010;
    localparam logic [4:0] P_ERR   = 5'b00001;

    typedef struct {
        bit         rst;
        bit         on;
        bit         off;
        logic [6:0] key;
        logic [6:0] vel;
        logic [3:0] vf;
        logic [4:0] pul;
        logic [4:0] pul0;
        logic [1:0] adr;
        logic [7:0] kv;
        logic [7:0] von;
        logic [7:0] voff;
        logic [3:0] keys;
        logic [2:0] act;
    } vec_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    vec_t vecs [16];

    voice_allocator_if #(.VOICES(VOICES)) bus1 ();
    voice_allocator_if #(.VOICES(VOICES)) bus0 ();

    voice_allocator #(.VOICES(VOICES), .STEAL_MODE(1)) dut (
        .CLOCK_25 (clock),
        .reset_reg(reset),
        .bus      (bus1)
    );

    voice_allocator #(.VOICES(VOICES), .STEAL_MODE(0)) dutDrop (
        .CLOCK_25 (clock),
        .reset_reg(reset),
        .bus      (bus0)
    );

    assign bus0.note_on_req  = bus1.note_on_req;
    assign bus0.note_off_req = bus1.note_off_req;
    assign bus0.req_key      = bus1.req_key;
    assign bus0.req_vel      = bus1.req_vel;
    assign bus0.voice_free   = bus1.voice_free;

    logic [4:0] pulses1, pulses0;
    assign pulses1 = {bus1.note_on, bus1.note_off, bus1.steal, bus1.drop, bus1.off_note_error};
    assign pulses0 = {bus0.note_on, bus0.note_off, bus0.steal, bus0.drop, bus0.off_note_error};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Issues one request and walks it to the cycle right after the commit edge.
    task automatic applyStimulus(input logic on, input logic off, input logic [6:0] key,
                                 input logic [6:0] vel, input logic [3:0] vf);
        @(negedge clock);
        bus1.note_on_req  = on;
        bus1.note_off_req = off;
        bus1.req_key      = key;
        bus1.req_vel      = vel;
        bus1.voice_free   = vf;
        @(posedge clock);
        #1;
        bus1.note_on_req  = 1'b0;
        bus1.note_off_req = 1'b0;
        checkOutput("busyAccept", 32'(bus1.busy), 32'd1);
        repeat (VOICES) @(posedge clock);
        #1;
        checkOutput("preCommitPulse", 32'(pulses1), 32'd0);
        checkOutput("preCommitBusy", 32'(bus1.busy), 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".keys"}, 32'(bus1.keys_on), 32'd0);
        checkOutput({tag, ".act"}, 32'(bus1.active_keys), 32'd0);
        checkOutput({tag, ".busy"}, 32'(bus1.busy), 32'd0);
        checkOutput({tag, ".pulses"}, 32'(pulses1), 32'd0);
        checkOutput({tag, ".cur"}, {bus1.cur_key_val, bus1.cur_vel_on, bus1.cur_vel_off, 6'd0, bus1.cur_key_adr}, 32'd0);
    endtask

    initial begin
        int sawPulse;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus1.note_on_req  = 1'b0;
        bus1.note_off_req = 1'b0;
        bus1.req_key      = '0;
        bus1.req_vel      = '0;
        bus1.voice_free   = '1;

        vecs[0]  = '{0, 1, 0, 7'd60, 7'd100, 4'hF, P_ON,           P_ON,   2'd0, 8'd60, 8'd100, 8'd0,  4'b0001, 3'd1};
        vecs[1]  = '{0, 1, 0, 7'd60, 7'd90,  4'hF, P_ON,           P_ON,   2'd0, 8'd60, 8'd90,  8'd0,  4'b0001, 3'd1};
        vecs[2]  = '{0, 0, 1, 7'd60, 7'd40,  4'hF, P_OFF,          P_OFF,  2'd0, 8'd60, 8'd90,  8'd40, 4'b0000, 3'd0};
        vecs[3]  = '{0, 0, 1, 7'd72, 7'd10,  4'hF, P_ERR,          P_ERR,  2'd0, 8'd60, 8'd90,  8'd40, 4'b0000, 3'd0};
        vecs[4]  = '{0, 1, 0, 7'd61, 7'd50,  4'hF, P_ON,           P_ON,   2'd0, 8'd61, 8'd50,  8'd40, 4'b0001, 3'd1};
        vecs[5]  = '{0, 1, 1, 7'd61, 7'd20,  4'hF, P_OFF,          P_OFF,  2'd0, 8'd61, 8'd50,  8'd20, 4'b0000, 3'd0};
        vecs[6]  = '{0, 1, 0, 7'd60, 7'd100, 4'hF, P_ON,           P_ON,   2'd0, 8'd60, 8'd100, 8'd20, 4'b0001, 3'd1};
        vecs[7]  = '{0, 1, 0, 7'd62, 7'd101, 4'hF, P_ON,           P_ON,   2'd1, 8'd62, 8'd101, 8'd20, 4'b0011, 3'd2};
        vecs[8]  = '{0, 1, 0, 7'd64, 7'd102, 4'hF, P_ON,           P_ON,   2'd2, 8'd64, 8'd102, 8'd20, 4'b0111, 3'd3};
        vecs[9]  = '{0, 1, 0, 7'd65, 7'd103, 4'hF, P_ON,           P_ON,   2'd3, 8'd65, 8'd103, 8'd20, 4'b1111, 3'd4};
        vecs[10] = '{0, 1, 0, 7'd67, 7'd104, 4'h0, P_ON | P_STEAL, P_DROP, 2'd0, 8'd67, 8'd104, 8'd20, 4'b1111, 3'd4};
        vecs[11] = '{1, 1, 0, 7'd50, 7'd1,   4'hF, P_ON,           P_ON,   2'd0, 8'd50, 8'd1,   8'd0,  4'b0001, 3'd1};
        vecs[12] = '{0, 1, 0, 7'd51, 7'd2,   4'hF, P_ON,           P_ON,   2'd1, 8'd51, 8'd2,   8'd0,  4'b0011, 3'd2};
        vecs[13] = '{0, 0, 1, 7'd50, 7'd3,   4'hF, P_OFF,          P_OFF,  2'd0, 8'd50, 8'd2,   8'd3,  4'b0010, 3'd1};
        vecs[14] = '{0, 1, 0, 7'd52, 7'd4,   4'h0, P_ON,           P_ON,   2'd3, 8'd52, 8'd4,   8'd3,  4'b1010, 3'd2};
        vecs[15] = '{0, 1, 0, 7'd53, 7'd5,   4'h1, P_ON,           P_ON,   2'd0, 8'd53, 8'd5,   8'd3,  4'b1011, 3'd3};

        repeat (2) @(posedge clock);
        #1;
        checkResetState("initReset");
        #2 reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].rst) begin
                @(posedge clock);
                #1 reset = 1'b1;
                #1 checkResetState($sformatf("v%0d.reset", i));
                #1 reset = 1'b0;
            end
            applyStimulus(vecs[i].on, vecs[i].off, vecs[i].key, vecs[i].vel, vecs[i].vf);
            checkOutput($sformatf("v%0d.pulses", i), 32'(pulses1), 32'(vecs[i].pul));
            checkOutput($sformatf("v%0d.pulsesDrop", i), 32'(pulses0), 32'(vecs[i].pul0));
            checkOutput($sformatf("v%0d.adr", i), 32'(bus1.cur_key_adr), 32'(vecs[i].adr));
            checkOutput($sformatf("v%0d.keyVal", i), 32'(bus1.cur_key_val), 32'(vecs[i].kv));
            checkOutput($sformatf("v%0d.velOn", i), 32'(bus1.cur_vel_on), 32'(vecs[i].von));
            checkOutput($sformatf("v%0d.velOff", i), 32'(bus1.cur_vel_off), 32'(vecs[i].voff));
            checkOutput($sformatf("v%0d.keysOn", i), 32'(bus1.keys_on), 32'(vecs[i].keys));
            checkOutput($sformatf("v%0d.active", i), 32'(bus1.active_keys), 32'(vecs[i].act));
            checkOutput($sformatf("v%0d.keysOnDrop", i), 32'(bus0.keys_on), 32'(vecs[i].keys));
            checkOutput($sformatf("v%0d.busyDone", i), 32'(bus1.busy), 32'd0);
        end

        // Reset in the middle of a scan must abort it and restore the age ranks.
        @(negedge clock);
        bus1.note_on_req = 1'b1;
        bus1.req_key     = 7'd70;
        bus1.req_vel     = 7'd70;
        bus1.voice_free  = 4'hF;
        @(posedge clock);
        #1 bus1.note_on_req = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        #1 checkResetState("midScanReset");
        #2 reset = 1'b0;
        sawPulse = 0;
        repeat (VOICES + 3) begin
            @(posedge clock);
            #1;
            if ((pulses1 != 5'd0) || bus1.busy) sawPulse++;
        end
        checkOutput("abortNoPulse", 32'(sawPulse), 32'd0);
        checkOutput("abortKeys", 32'(bus1.keys_on), 32'd0);

        #1 reset = 1'b1;
        #1 reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 7'd71, 7'd11, 4'hF);
        checkOutput("postReset.pulses", 32'(pulses1), 32'(P_ON));
        checkOutput("postReset.adr", 32'(bus1.cur_key_adr), 32'd0);
        applyStimulus(1'b1, 1'b0, 7'd72, 7'd12, 4'h0);
        checkOutput("rankRestore.adr", 32'(bus1.cur_key_adr), 32'd3);
        checkOutput("rankRestore.keys", 32'(bus1.keys_on), 32'b1001);

        // A request raised while busy must be ignored and must not disturb the latched key.
        @(negedge clock);
        bus1.note_on_req = 1'b1;
        bus1.req_key     = 7'd80;
        bus1.req_vel     = 7'd33;
        bus1.voice_free  = 4'hF;
        @(posedge clock);
        #1 bus1.note_on_req = 1'b0;
        @(negedge clock);
        bus1.note_on_req = 1'b1;
        bus1.req_key     = 7'd81;
        bus1.req_vel     = 7'd44;
        @(posedge clock);
        #1 bus1.note_on_req = 1'b0;
        repeat (VOICES) @(posedge clock);
        #1;
        checkOutput("busyIgnore.pulses", 32'(pulses1), 32'(P_ON));
        checkOutput("busyIgnore.keyVal", 32'(bus1.cur_key_val), 32'd80);
        checkOutput("busyIgnore.velOn", 32'(bus1.cur_vel_on), 32'd33);
        checkOutput("busyIgnore.adr", 32'(bus1.cur_key_adr), 32'd1);
        checkOutput("busyIgnore.keys", 32'(bus1.keys_on), 32'b1011);
        checkOutput("busyIgnore.act", 32'(bus1.active_keys), 32'd3);
        sawPulse = 0;
        repeat (VOICES + 2) begin
            @(posedge clock);
            #1;
            if ((pulses1 != 5'd0) || bus1.busy) sawPulse++;
        end
        checkOutput("busyIgnore.noExtra", 32'(sawPulse), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
